// File: rtl/core_tile_pkg.sv
// core_tile_pkg: shared state encoding, rotation codes and clog2 for the tile address generator
package core_tile_pkg;
  typedef enum logic [1:0] {IDLE, FILL, ROTATE, DRAIN} state_t;
  typedef enum logic [1:0] {DEG_0, DEG_90, DEG_180, DEG_270} deg_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/core_tile_addrgen_if.sv
// core_tile_addrgen_if: control, DMA handshake and buffer address bundle of the tile address generator
interface core_tile_addrgen_if import core_tile_pkg::*; #(
  parameter int TILE = 8,
  parameter int CH = 3
);
  localparam int AW = clog2(TILE * TILE * CH);
  localparam int VW = clog2(TILE) + 1;
  logic I_TA_START;
  logic [1:0] I_TA_DEGREES;
  logic I_TA_DIRECTION;
  logic [VW-1:0] I_TA_VALID_W;
  logic [VW-1:0] I_TA_VALID_H;
  logic I_TA_RD_VALID;
  logic O_TA_RD_READY;
  logic O_TA_WR_VALID;
  logic I_TA_WR_READY;
  logic O_TA_IMEM_WE;
  logic [AW-1:0] O_TA_IMEM_WADDR;
  logic [AW-1:0] O_TA_IMEM_RADDR;
  logic O_TA_OMEM_WE;
  logic [AW-1:0] O_TA_OMEM_WADDR;
  logic O_TA_OMEM_ZERO;
  logic [AW-1:0] O_TA_OMEM_RADDR;
  logic O_TA_BUSY;
  logic O_TA_DONE;
  modport master (
    output I_TA_START, I_TA_DEGREES, I_TA_DIRECTION, I_TA_VALID_W, I_TA_VALID_H, I_TA_RD_VALID, I_TA_WR_READY,
    input O_TA_RD_READY, O_TA_WR_VALID, O_TA_IMEM_WE, O_TA_IMEM_WADDR, O_TA_IMEM_RADDR, O_TA_OMEM_WE,
    input O_TA_OMEM_WADDR, O_TA_OMEM_ZERO, O_TA_OMEM_RADDR, O_TA_BUSY, O_TA_DONE
  );
  modport slave (
    input I_TA_START, I_TA_DEGREES, I_TA_DIRECTION, I_TA_VALID_W, I_TA_VALID_H, I_TA_RD_VALID, I_TA_WR_READY,
    output O_TA_RD_READY, O_TA_WR_VALID, O_TA_IMEM_WE, O_TA_IMEM_WADDR, O_TA_IMEM_RADDR, O_TA_OMEM_WE,
    output O_TA_OMEM_WADDR, O_TA_OMEM_ZERO, O_TA_OMEM_RADDR, O_TA_BUSY, O_TA_DONE
  );
endinterface

// File: rtl/core_tile_rotmap.sv
// core_tile_rotmap: maps output pixel index n to its source pixel under r quarter-turns CCW, flags padding
module core_tile_rotmap import core_tile_pkg::*; #(
  parameter int TILE = 8,
  localparam int LT = clog2(TILE)
) (
  input logic [2*LT-1:0] n,
  input logic [1:0] r,
  input logic [LT:0] vw,
  input logic [LT:0] vh,
  output logic [LT-1:0] i,
  output logic [LT-1:0] j,
  output logic pad
);
  logic [LT-1:0] y, x;
  assign y = n[2*LT-1:LT];
  assign x = n[LT-1:0];
  // TILE is a power of two, so TILE-1-v is just ~v
  always_comb begin
    i = r == DEG_0 ? y : r == DEG_90 ? x : r == DEG_180 ? ~y : ~x;
    j = r == DEG_0 ? x : r == DEG_90 ? ~y : r == DEG_180 ? ~x : y;
    pad = {1'b0, i} >= vh || {1'b0, j} >= vw;
  end
endmodule

// File: rtl/core_tile_addrgen.sv
// core_tile_addrgen: sequences one tile through fill, rotate and drain,
// generating input/output buffer addresses and DMA beat handshakes
module core_tile_addrgen import core_tile_pkg::*; #(
  parameter int TILE = 8,
  parameter int CH = 3
) (
  input logic I_TA_HCLK,
  input logic I_TA_RESET,
  core_tile_addrgen_if.slave bus
);
  localparam int NB = TILE * TILE * CH;
  localparam int AW = clog2(NB);
  localparam int NBEAT = NB / 4;
  localparam int TT = TILE * TILE;
  localparam int LT = clog2(TILE);
  localparam int VW = LT + 1;
  state_t state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [1:0] r_q, r_d;
  logic [VW-1:0] vw_q, vw_d, vh_q, vh_d;
  logic we_q, we_d, zero_q, zero_d, done_q, done_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [LT-1:0] src_i, src_j;
  logic pad, rotating, last_beat;
  function automatic logic [VW-1:0] clamp(input logic [VW-1:0] v);
    return (v == '0 || v > VW'(TILE)) ? VW'(TILE) : v;
  endfunction
  core_tile_rotmap #(.TILE(TILE)) u_rotmap (
    .n(cnt_q[2*LT-1:0]),
    .r(r_q),
    .vw(vw_q),
    .vh(vh_q),
    .i(src_i),
    .j(src_j),
    .pad(pad)
  );
  assign rotating = state_q == ROTATE && cnt_q < (AW+1)'(TT);
  assign last_beat = cnt_q == (AW+1)'(NBEAT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    vw_d = vw_q;
    vh_d = vh_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: if (bus.I_TA_START) begin
        state_d = FILL;
        cnt_d = '0;
        r_d = bus.I_TA_DIRECTION ? bus.I_TA_DEGREES : 2'd0 - bus.I_TA_DEGREES;
        vw_d = clamp(bus.I_TA_VALID_W);
        vh_d = clamp(bus.I_TA_VALID_H);
      end
      FILL: if (bus.I_TA_RD_VALID) begin
        state_d = last_beat ? ROTATE : FILL;
        cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      end
      ROTATE: begin
        state_d = cnt_q == (AW+1)'(TT) ? DRAIN : ROTATE;
        cnt_d = cnt_q == (AW+1)'(TT) ? '0 : cnt_q + 1'b1;
      end
      DRAIN: if (bus.I_TA_WR_READY) begin
        state_d = last_beat ? IDLE : DRAIN;
        cnt_d = last_beat ? '0 : cnt_q + 1'b1;
        done_d = last_beat;
      end
      default: ;
    endcase
    // output write trails its buffer read by the one-cycle read latency
    we_d = rotating;
    waddr_d = rotating ? AW'(cnt_q * CH) : '0;
    zero_d = rotating && pad;
  end
  always_ff @(posedge I_TA_HCLK or posedge I_TA_RESET) begin
    if (I_TA_RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      r_q <= '0;
      vw_q <= '0;
      vh_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      zero_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      vw_q <= vw_d;
      vh_q <= vh_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end
  assign bus.O_TA_RD_READY = state_q == FILL;
  assign bus.O_TA_IMEM_WE = state_q == FILL && bus.I_TA_RD_VALID;
  assign bus.O_TA_IMEM_WADDR = state_q == FILL ? {cnt_q[AW-3:0], 2'b00} : '0;
  assign bus.O_TA_IMEM_RADDR = rotating ? AW'((src_i * TILE + src_j) * CH) : '0;
  assign bus.O_TA_OMEM_WE = we_q;
  assign bus.O_TA_OMEM_WADDR = waddr_q;
  assign bus.O_TA_OMEM_ZERO = zero_q;
  assign bus.O_TA_WR_VALID = state_q == DRAIN;
  assign bus.O_TA_OMEM_RADDR = state_q == DRAIN ? {cnt_q[AW-3:0], 2'b00} : '0;
  assign bus.O_TA_BUSY = state_q != IDLE;
  assign bus.O_TA_DONE = done_q;
endmodule

// File: tb/tb_core_tile_addrgen.sv
// tb_core_tile_addrgen: directed + randomized tile runs checked against a coordinate-rotation reference model
module tb_core_tile_addrgen;
  import core_tile_pkg::*;
  localparam int T = 8, C = 3, TT = T * T, NBEAT = T * T * C / 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  core_tile_addrgen_if #(.TILE(8), .CH(3)) bus ();
  core_tile_addrgen_if #(.TILE(4), .CH(4)) bus2 ();
  core_tile_addrgen #(.TILE(8), .CH(3)) dut (.I_TA_HCLK(clk), .I_TA_RESET(rst), .bus(bus));
  core_tile_addrgen #(.TILE(4), .CH(4)) dut2 (.I_TA_HCLK(clk), .I_TA_RESET(rst), .bus(bus2));
  logic [63:0] outs1, outs2;
  assign outs1 = 64'({bus.O_TA_RD_READY, bus.O_TA_WR_VALID, bus.O_TA_IMEM_WE, bus.O_TA_IMEM_WADDR,
    bus.O_TA_IMEM_RADDR, bus.O_TA_OMEM_WE, bus.O_TA_OMEM_WADDR, bus.O_TA_OMEM_ZERO, bus.O_TA_OMEM_RADDR,
    bus.O_TA_BUSY, bus.O_TA_DONE});
  assign outs2 = 64'({bus2.O_TA_RD_READY, bus2.O_TA_WR_VALID, bus2.O_TA_IMEM_WE, bus2.O_TA_IMEM_WADDR,
    bus2.O_TA_IMEM_RADDR, bus2.O_TA_OMEM_WE, bus2.O_TA_OMEM_WADDR, bus2.O_TA_OMEM_ZERO, bus2.O_TA_OMEM_RADDR,
    bus2.O_TA_BUSY, bus2.O_TA_DONE});
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // source pixel of output (n/T, n%T): apply r successive quarter-turns to the coordinates
  function automatic void src(input int n, input int r, output int i, output int j);
    int a = n / T, b = n % T, t;
    for (int k = 0; k < r; k++) begin
      t = a;
      a = b;
      b = T - 1 - t;
    end
    i = a;
    j = b;
  endfunction
  task automatic run_tile(input logic [1:0] deg, input logic dir, input int vw, input int vh,
                          input int rd_mode, input int wr_mode, output int zeros);
    int r = dir ? int'(deg) : (4 - int'(deg)) % 4;
    int vwe = (vw == 0 || vw > T) ? T : vw;
    int vhe = (vh == 0 || vh > T) ? T : vh;
    int beat = 0, cyc = 0, i, j;
    logic rv, wv;
    zeros = 0;
    @(negedge clk);
    bus.I_TA_START = 1'b1;
    bus.I_TA_DEGREES = deg;
    bus.I_TA_DIRECTION = dir;
    bus.I_TA_VALID_W = 4'(vw);
    bus.I_TA_VALID_H = 4'(vh);
    @(negedge clk);
    bus.I_TA_START = 1'b0;
    bus.I_TA_DEGREES = deg ^ 2'd1;
    bus.I_TA_DIRECTION = ~dir;
    bus.I_TA_VALID_W = 4'($urandom_range(0, 15));
    bus.I_TA_VALID_H = 4'($urandom_range(0, 15));
    while (beat < NBEAT && cyc < 1000) begin
      rv = rd_mode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
      bus.I_TA_RD_VALID = rv;
      bus.I_TA_START = beat == 3;
      #1;
      chk("fill_ready", bus.O_TA_RD_READY, 1);
      chk("fill_we", bus.O_TA_IMEM_WE, rv);
      if (rv) chk("fill_waddr", bus.O_TA_IMEM_WADDR, 4 * beat);
      chk("fill_busy", {bus.O_TA_BUSY, bus.O_TA_WR_VALID, bus.O_TA_OMEM_WE}, 3'b100);
      @(negedge clk);
      beat += int'(rv);
      cyc++;
    end
    bus.I_TA_RD_VALID = 1'b0;
    bus.I_TA_START = 1'b0;
    if (beat < NBEAT) chk("fill_timeout", beat, NBEAT);
    for (int k = 0; k <= TT; k++) begin
      #1;
      if (k < TT) begin
        src(k, r, i, j);
        chk("rot_raddr", bus.O_TA_IMEM_RADDR, (i * T + j) * C);
      end
      chk("rot_owe", bus.O_TA_OMEM_WE, k > 0);
      if (k > 0) begin
        src(k - 1, r, i, j);
        chk("rot_owaddr", bus.O_TA_OMEM_WADDR, (k - 1) * C);
        chk("rot_zero", bus.O_TA_OMEM_ZERO, i >= vhe || j >= vwe);
        zeros += int'(bus.O_TA_OMEM_ZERO);
      end
      chk("rot_state", {bus.O_TA_BUSY, bus.O_TA_RD_READY, bus.O_TA_WR_VALID}, 3'b100);
      @(negedge clk);
    end
    beat = 0;
    cyc = 0;
    while (beat < NBEAT && cyc < 1000) begin
      wv = wr_mode == 0 ? 1'b1 : wr_mode == 2 ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      bus.I_TA_WR_READY = wv;
      #1;
      chk("drain_valid", bus.O_TA_WR_VALID, 1);
      chk("drain_raddr", bus.O_TA_OMEM_RADDR, 4 * beat);
      chk("drain_done", bus.O_TA_DONE, 0);
      @(negedge clk);
      beat += int'(wv);
      cyc++;
    end
    bus.I_TA_WR_READY = 1'b0;
    if (beat < NBEAT) chk("drain_timeout", beat, NBEAT);
    #1 chk("done_pulse", {bus.O_TA_DONE, bus.O_TA_BUSY}, 2'b10);
    @(negedge clk);
    #1 chk("done_clear", {bus.O_TA_DONE, bus.O_TA_BUSY, bus.O_TA_WR_VALID}, 3'b000);
  endtask
  initial begin
    int z, cyc;
    bus.I_TA_START = 1'b0;
    bus.I_TA_DEGREES = '0;
    bus.I_TA_DIRECTION = 1'b0;
    bus.I_TA_VALID_W = '0;
    bus.I_TA_VALID_H = '0;
    bus.I_TA_RD_VALID = 1'b0;
    bus.I_TA_WR_READY = 1'b0;
    bus2.I_TA_START = 1'b0;
    bus2.I_TA_DEGREES = '0;
    bus2.I_TA_DIRECTION = 1'b0;
    bus2.I_TA_VALID_W = '0;
    bus2.I_TA_VALID_H = '0;
    bus2.I_TA_RD_VALID = 1'b0;
    bus2.I_TA_WR_READY = 1'b0;
    #1 chk("reset_outs", outs1, 0);
    chk("reset_outs_t4", outs2, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_tile(DEG_0, 1'b1, 8, 8, 0, 0, z);
    run_tile(DEG_90, 1'b1, 8, 8, 1, 1, z);
    run_tile(DEG_90, 1'b0, 8, 8, 0, 1, z);
    run_tile(DEG_180, 1'b1, 0, 15, 1, 0, z);
    run_tile(DEG_0, 1'b1, 5, 8, 1, 2, z);
    chk("pad_count", z, 24);
    repeat (4) run_tile(2'($urandom), 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 15), 1, 1, z);
    @(negedge clk);
    bus.I_TA_START = 1'b1;
    bus.I_TA_DEGREES = DEG_0;
    bus.I_TA_DIRECTION = 1'b1;
    bus.I_TA_VALID_W = 4'd8;
    bus.I_TA_VALID_H = 4'd8;
    @(negedge clk);
    bus.I_TA_START = 1'b0;
    bus.I_TA_RD_VALID = 1'b1;
    repeat (20) @(negedge clk);
    #1 chk("pre_rst_waddr", bus.O_TA_IMEM_WADDR, 80);
    #2 rst = 1'b1;
    #1 chk("rst_async_outs", outs1, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.I_TA_RD_VALID = 1'b0;
    #1 chk("rst_idle_outs", outs1, 0);
    run_tile(DEG_270, 1'b0, 3, 6, 1, 1, z);
    @(negedge clk);
    bus2.I_TA_START = 1'b1;
    bus2.I_TA_DEGREES = DEG_270;
    bus2.I_TA_DIRECTION = 1'b1;
    bus2.I_TA_VALID_W = 3'd4;
    bus2.I_TA_VALID_H = 3'd4;
    bus2.I_TA_RD_VALID = 1'b1;
    bus2.I_TA_WR_READY = 1'b1;
    @(negedge clk);
    bus2.I_TA_START = 1'b0;
    cyc = 0;
    while (bus2.O_TA_RD_READY && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_fill_beats", cyc, 16);
    #1 chk("t4_first_raddr", bus2.O_TA_IMEM_RADDR, 48);
    cyc = 0;
    while (bus2.O_TA_BUSY && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_back_idle", bus2.O_TA_BUSY, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
